// File: rtl/axi_loopback_pkg.sv
// rtl/axi_loopback_pkg.sv - shared AXI constants, master state type and data pattern helper
package axi_loopback_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [7:0] LEN_SINGLE  = 8'd0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_WRESP,
      ST_READ,
      ST_RDATA,
      ST_FIN
   } mst_state_t;

   // AxSIZE encoding for a full-width beat
   function automatic logic [2:0] axsize_of(input int data_w);
      return 3'($clog2(data_w / 8));
   endfunction

   // Data word carried by transaction i
   function automatic logic [31:0] pattern_of(input logic [31:0] base, input logic [7:0] i);
      return base + {24'd0, i};
   endfunction

endpackage

// File: rtl/axi_mem_slave.sv
// rtl/axi_mem_slave.sv - single-beat AXI4 memory slave with range-checked responses
module axi_mem_slave
   import axi_loopback_pkg::*;
#(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 32,
   parameter int MEM_DEPTH = 1024
) (
   input  logic                i_aclk,
   input  logic                i_aresetn,
   input  logic [ADDR_W-1:0]   i_awaddr,
   input  logic [7:0]          i_awlen,
   input  logic [2:0]          i_awsize,
   input  logic [1:0]          i_awburst,
   input  logic                i_awvalid,
   output logic                o_awready,
   input  logic [DATA_W-1:0]   i_wdata,
   input  logic [DATA_W/8-1:0] i_wstrb,
   input  logic                i_wlast,
   input  logic                i_wvalid,
   output logic                o_wready,
   output logic [1:0]          o_bresp,
   output logic                o_bvalid,
   input  logic                i_bready,
   input  logic [ADDR_W-1:0]   i_araddr,
   input  logic [7:0]          i_arlen,
   input  logic [2:0]          i_arsize,
   input  logic [1:0]          i_arburst,
   input  logic                i_arvalid,
   output logic                o_arready,
   output logic [DATA_W-1:0]   o_rdata,
   output logic [1:0]          o_rresp,
   output logic                o_rlast,
   output logic                o_rvalid,
   input  logic                i_rready
);

   localparam int          STRB_W = DATA_W / 8;
   localparam int          MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [2:0]  AXSIZE = axsize_of(DATA_W);

   logic [DATA_W-1:0] r_mem [MEM_DEPTH];

   logic              r_aw_got, r_w_got, r_awbad, r_wbad;
   logic [ADDR_W-1:0] r_awaddr;
   logic [DATA_W-1:0] r_wdata;
   logic [STRB_W-1:0] r_wstrb;
   logic              r_bvalid, r_rvalid;
   logic [1:0]        r_bresp, r_rresp;
   logic [DATA_W-1:0] r_rdata;

   logic              w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wok, w_rok;
   logic [ADDR_W-1:0] w_awaddr;
   logic [DATA_W-1:0] w_wdata;
   logic [STRB_W-1:0] w_wstrb;
   logic              w_awbad, w_wbad;
   logic [ADDR_W-3:0] w_widx, w_ridx;

   assign o_awready = !r_aw_got && !r_bvalid;
   assign o_wready  = !r_w_got && !r_bvalid;
   assign o_arready = !r_rvalid;
   assign w_aw_hs   = i_awvalid && o_awready;
   assign w_w_hs    = i_wvalid && o_wready;
   assign w_ar_hs   = i_arvalid && o_arready;

   // A channel that arrived earlier is taken from its latch, otherwise straight off the bus
   assign w_awaddr = r_aw_got ? r_awaddr : i_awaddr;
   assign w_awbad  = r_aw_got ? r_awbad
                              : (i_awlen != LEN_SINGLE || i_awsize != AXSIZE || i_awburst != BURST_INCR);
   assign w_wdata  = r_w_got ? r_wdata : i_wdata;
   assign w_wstrb  = r_w_got ? r_wstrb : i_wstrb;
   assign w_wbad   = r_w_got ? r_wbad : !i_wlast;
   assign w_commit = i_aresetn && (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);
   assign w_widx   = w_awaddr[ADDR_W-1:2];
   assign w_wok    = (int'(w_widx) < MEM_DEPTH) && !w_awbad && !w_wbad;
   assign w_ridx   = i_araddr[ADDR_W-1:2];
   assign w_rok    = (int'(w_ridx) < MEM_DEPTH) && i_arlen == LEN_SINGLE
                     && i_arsize == AXSIZE && i_arburst == BURST_INCR;

   assign o_bvalid = r_bvalid;
   assign o_bresp  = r_bresp;
   assign o_rvalid = r_rvalid;
   assign o_rresp  = r_rresp;
   assign o_rdata  = r_rdata;
   assign o_rlast  = 1'b1;

   // Hold AW/W payloads that arrive ahead of their partner
   always_ff @(posedge i_aclk) begin
      if (w_aw_hs) begin
         r_awaddr <= i_awaddr;
         r_awbad  <= (i_awlen != LEN_SINGLE || i_awsize != AXSIZE || i_awburst != BURST_INCR);
      end
      if (w_w_hs) begin
         r_wdata <= i_wdata;
         r_wstrb <= i_wstrb;
         r_wbad  <= !i_wlast;
      end
   end

   // Storage array: byte-lane write once both halves of a write are present; never reset
   always_ff @(posedge i_aclk) begin
      if (w_commit && w_wok) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (w_wstrb[b]) r_mem[w_widx[MEM_AW-1:0]][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
   end

   // Write channel control: latch AW/W, raise B the cycle after both are in, hold until taken
   always_ff @(posedge i_aclk) begin
      if (!i_aresetn) begin
         r_aw_got <= 1'b0;
         r_w_got  <= 1'b0;
         r_bvalid <= 1'b0;
         r_bresp  <= RESP_OKAY;
      end else if (w_commit) begin
         r_aw_got <= 1'b0;
         r_w_got  <= 1'b0;
         r_bvalid <= 1'b1;
         r_bresp  <= w_wok ? RESP_OKAY : RESP_SLVERR;
      end else begin
         if (w_aw_hs) r_aw_got <= 1'b1;
         if (w_w_hs) r_w_got <= 1'b1;
         if (r_bvalid && i_bready) r_bvalid <= 1'b0;
      end
   end

   // Read channel: one-cycle latency from AR acceptance to R, held until taken
   always_ff @(posedge i_aclk) begin
      if (!i_aresetn) begin
         r_rvalid <= 1'b0;
         r_rresp  <= RESP_OKAY;
         r_rdata  <= '0;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rresp  <= w_rok ? RESP_OKAY : RESP_SLVERR;
         r_rdata  <= w_rok ? r_mem[w_ridx[MEM_AW-1:0]] : '0;
      end else if (r_rvalid && i_rready) begin
         r_rvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/axi_loopback_mem_chip.sv
// rtl/axi_loopback_mem_chip.sv - write/readback traffic master, handshake monitor and memory slave
module axi_loopback_mem_chip
   import axi_loopback_pkg::*;
#(
   parameter int                ADDR_W    = 12,
   parameter int                DATA_W    = 32,
   parameter int                MEM_DEPTH = 1024,
   parameter int                NUM_TXN   = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter logic [31:0]       PATTERN   = 32'hA5A5_0000
) (
   input  logic       aclk,
   input  logic       aresetn,
   output logic       done,
   output logic       pass,
   output logic [7:0] wr_count,
   output logic [7:0] rd_count,
   output logic [7:0] err_count
);

   localparam logic [7:0] LAST_IDX = 8'(NUM_TXN - 1);

   mst_state_t        r_state;
   logic [7:0]        r_idx;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready, r_done;
   logic [7:0]        r_wr_count, r_rd_count, r_err_count;

   logic                w_awvalid, w_awready, w_wvalid, w_wready, w_bvalid, w_bready;
   logic                w_arvalid, w_arready, w_rvalid, w_rready, w_rlast;
   logic [1:0]          w_bresp, w_rresp;
   logic [DATA_W-1:0]   w_rdata;
   logic [7:0]          w_axlen;
   logic [2:0]          w_axsize;
   logic [1:0]          w_axburst;
   logic [DATA_W/8-1:0] w_wstrb;
   logic                w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_b_err, w_r_err;
   logic [8:0]          w_err_sum;

   assign w_awvalid = r_awvalid;
   assign w_wvalid  = r_wvalid;
   assign w_bready  = r_bready;
   assign w_arvalid = r_arvalid;
   assign w_rready  = r_rready;
   assign w_axlen   = LEN_SINGLE;
   assign w_axsize  = axsize_of(DATA_W);
   assign w_axburst = BURST_INCR;
   assign w_wstrb   = '1;
   assign w_aw_hs   = w_awvalid && w_awready;
   assign w_w_hs    = w_wvalid && w_wready;
   assign w_b_hs    = w_bvalid && w_bready;
   assign w_ar_hs   = w_arvalid && w_arready;
   assign w_r_hs    = w_rvalid && w_rready;

   axi_mem_slave #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_slave (
      .i_aclk    (aclk),
      .i_aresetn (aresetn),
      .i_awaddr  (r_addr),
      .i_awlen   (w_axlen),
      .i_awsize  (w_axsize),
      .i_awburst (w_axburst),
      .i_awvalid (w_awvalid),
      .o_awready (w_awready),
      .i_wdata   (r_wdata),
      .i_wstrb   (w_wstrb),
      .i_wlast   (1'b1),
      .i_wvalid  (w_wvalid),
      .o_wready  (w_wready),
      .o_bresp   (w_bresp),
      .o_bvalid  (w_bvalid),
      .i_bready  (w_bready),
      .i_araddr  (r_addr),
      .i_arlen   (w_axlen),
      .i_arsize  (w_axsize),
      .i_arburst (w_axburst),
      .i_arvalid (w_arvalid),
      .o_arready (w_arready),
      .o_rdata   (w_rdata),
      .o_rresp   (w_rresp),
      .o_rlast   (w_rlast),
      .o_rvalid  (w_rvalid),
      .i_rready  (w_rready)
   );

   // Traffic master: write NUM_TXN words, read them back in order, then park in FIN
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state   <= ST_IDLE;
         r_idx     <= 8'd0;
         r_addr    <= BASE_ADDR;
         r_wdata   <= '0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_arvalid <= 1'b0;
         r_rready  <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state   <= ST_WRITE;
               r_idx     <= 8'd0;
               r_addr    <= BASE_ADDR;
               r_wdata   <= DATA_W'(pattern_of(PATTERN, 8'd0));
               r_awvalid <= 1'b1;
               r_wvalid  <= 1'b1;
            end
            ST_WRITE: begin
               if (w_aw_hs) r_awvalid <= 1'b0;
               if (w_w_hs) r_wvalid <= 1'b0;
               if ((!r_awvalid || w_aw_hs) && (!r_wvalid || w_w_hs)) begin
                  r_state  <= ST_WRESP;
                  r_bready <= 1'b1;
               end
            end
            ST_WRESP: begin
               if (w_b_hs) begin
                  r_bready <= 1'b0;
                  if (r_idx == LAST_IDX) begin
                     r_idx     <= 8'd0;
                     r_addr    <= BASE_ADDR;
                     r_arvalid <= 1'b1;
                     r_state   <= ST_READ;
                  end else begin
                     r_idx     <= r_idx + 8'd1;
                     r_addr    <= r_addr + ADDR_W'(4);
                     r_wdata   <= DATA_W'(pattern_of(PATTERN, r_idx + 8'd1));
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_state   <= ST_WRITE;
                  end
               end
            end
            ST_READ: begin
               if (w_ar_hs) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= ST_RDATA;
               end
            end
            ST_RDATA: begin
               if (w_r_hs) begin
                  r_rready <= 1'b0;
                  if (r_idx == LAST_IDX) begin
                     r_done  <= 1'b1;
                     r_state <= ST_FIN;
                  end else begin
                     r_idx     <= r_idx + 8'd1;
                     r_addr    <= r_addr + ADDR_W'(4);
                     r_arvalid <= 1'b1;
                     r_state   <= ST_READ;
                  end
               end
            end
            ST_FIN:  r_done <= 1'b1;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Monitor error sources; reads arrive in order, so rd_count indexes the expected word
   assign w_b_err   = w_b_hs && (w_bresp != RESP_OKAY);
   assign w_r_err   = w_r_hs && ((w_rresp != RESP_OKAY) ||
                                 (w_rdata != DATA_W'(pattern_of(PATTERN, r_rd_count))));
   assign w_err_sum = {1'b0, r_err_count} + {8'd0, w_b_err} + {8'd0, w_r_err};

   // Monitor counters: one cycle behind their handshakes, error count saturating
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_wr_count  <= 8'd0;
         r_rd_count  <= 8'd0;
         r_err_count <= 8'd0;
      end else begin
         if (w_b_hs) r_wr_count <= r_wr_count + 8'd1;
         if (w_r_hs) r_rd_count <= r_rd_count + 8'd1;
         r_err_count <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
      end
   end

   assign done      = r_done;
   assign pass      = r_done && (r_err_count == 8'd0);
   assign wr_count  = r_wr_count;
   assign rd_count  = r_rd_count;
   assign err_count = r_err_count;

   // A stalled VALID stays up with an unchanged payload until it is accepted
   a_aw_stable: assert property (@(posedge aclk) disable iff (!aresetn)
      (w_awvalid && !w_awready) |=> (w_awvalid && $stable(r_addr)));
   a_w_stable: assert property (@(posedge aclk) disable iff (!aresetn)
      (w_wvalid && !w_wready) |=> (w_wvalid && $stable(r_wdata)));
   a_b_stable: assert property (@(posedge aclk) disable iff (!aresetn)
      (w_bvalid && !w_bready) |=> (w_bvalid && $stable(w_bresp)));
   a_ar_stable: assert property (@(posedge aclk) disable iff (!aresetn)
      (w_arvalid && !w_arready) |=> (w_arvalid && $stable(r_addr)));
   a_r_stable: assert property (@(posedge aclk) disable iff (!aresetn)
      (w_rvalid && !w_rready) |=> (w_rvalid && $stable({w_rdata, w_rresp, w_rlast})));

endmodule

// File: tb/tb_axi_loopback_mem_chip.sv
// tb/tb_axi_loopback_mem_chip.sv - directed checks of the AXI loopback block
module tb_axi_loopback_mem_chip;

   logic       aclk = 1'b0;
   logic       rstn_a, rstn_b;
   logic       done_a, pass_a, done_o, pass_o, done_b, pass_b;
   logic [7:0] wr_a, rd_a, err_a, wr_o, rd_o, err_o, wr_b, rd_b, err_b;

   int n_checks = 0;
   int n_errors = 0;
   int cyc, n_oor_b, n_oor_r;
   logic ar_seen, ar_chk, valid_seen;

   always #10 aclk = ~aclk;

   axi_loopback_mem_chip u_dut (
      .aclk (aclk), .aresetn (rstn_a), .done (done_a), .pass (pass_a),
      .wr_count (wr_a), .rd_count (rd_a), .err_count (err_a)
   );

   axi_loopback_mem_chip #(.MEM_DEPTH (8), .NUM_TXN (10)) u_oor (
      .aclk (aclk), .aresetn (rstn_b), .done (done_o), .pass (pass_o),
      .wr_count (wr_o), .rd_count (rd_o), .err_count (err_o)
   );

   axi_loopback_mem_chip #(.BASE_ADDR (12'h100)) u_base (
      .aclk (aclk), .aresetn (rstn_b), .done (done_b), .pass (pass_b),
      .wr_count (wr_b), .rd_count (rd_b), .err_count (err_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [4:0] dut_valids();
      return {u_dut.w_awvalid, u_dut.w_wvalid, u_dut.w_bvalid, u_dut.w_arvalid, u_dut.w_rvalid};
   endfunction

   initial begin
      rstn_a = 1'b0;
      rstn_b = 1'b0;
      repeat (5) tick();
      chk("reset_counters", 32'({wr_a, rd_a, err_a}), 32'd0);
      chk("reset_done_pass", 32'({done_a, pass_a}), 32'd0);
      chk("reset_valids", 32'(dut_valids()), 32'd0);

      rstn_a = 1'b1;
      rstn_b = 1'b1;
      chk("awvalid_before_start", 32'(u_dut.w_awvalid), 32'd0);
      tick();
      chk("aw_w_handshake_cycle2",
          32'({u_dut.w_awvalid, u_dut.w_awready, u_dut.w_wvalid, u_dut.w_wready}), 32'hF);
      chk("bvalid_low_at_accept", 32'(u_dut.w_bvalid), 32'd0);
      tick();
      chk("bvalid_1cycle_after_accept", 32'(u_dut.w_bvalid), 32'd1);
      chk("awvalid_dropped", 32'({u_dut.w_awvalid, u_dut.w_wvalid}), 32'd0);
      tick();
      chk("wr_count_first", 32'(wr_a), 32'd1);

      ar_seen = 1'b0;
      ar_chk  = 1'b0;
      n_oor_b = 0;
      n_oor_r = 0;
      cyc     = 0;
      while (!(done_a && done_o && done_b) && cyc < 2000) begin
         if (u_oor.w_bvalid && u_oor.w_bready && u_oor.w_bresp == 2'b10) n_oor_b++;
         if (u_oor.w_rvalid && u_oor.w_rready && u_oor.w_rresp == 2'b10 && u_oor.w_rdata == 32'd0)
            n_oor_r++;
         if (ar_seen && !ar_chk) begin
            chk("rvalid_1cycle_after_ar", 32'(u_dut.w_rvalid), 32'd1);
            ar_chk = 1'b1;
         end
         if (!ar_seen && u_dut.w_arvalid && u_dut.w_arready) begin
            chk("rvalid_low_at_ar", 32'(u_dut.w_rvalid), 32'd0);
            ar_seen = 1'b1;
         end
         tick();
         cyc++;
      end
      chk("ar_handshake_seen", 32'(ar_chk), 32'd1);
      chk("main_done", 32'(done_a), 32'd1);
      chk("main_counts", 32'({wr_a, rd_a, err_a}), {8'd0, 8'd16, 8'd16, 8'd0});
      chk("main_pass", 32'(pass_a), 32'd1);
      chk("main_mem5", u_dut.u_slave.r_mem[5], 32'hA5A5_0005);

      chk("oor_slverr_b", 32'(n_oor_b), 32'd2);
      chk("oor_slverr_r_zero", 32'(n_oor_r), 32'd2);
      chk("oor_counts", 32'({wr_o, rd_o, err_o}), {8'd0, 8'd10, 8'd10, 8'd4});
      chk("oor_done_pass", 32'({done_o, pass_o}), 32'b10);

      chk("base_done_pass", 32'({done_b, pass_b}), 32'b11);
      chk("base_err", 32'(err_b), 32'd0);
      chk("base_mem64", u_base.u_slave.r_mem[64], 32'hA5A5_0000);
      chk("base_mem79", u_base.u_slave.r_mem[79], 32'hA5A5_000F);

      valid_seen = 1'b0;
      repeat (100) begin
         tick();
         if (dut_valids() != 5'd0) valid_seen = 1'b1;
      end
      chk("fin_no_valid", 32'(valid_seen), 32'd0);
      chk("fin_counts_frozen", 32'({wr_a, rd_a, err_a}), {8'd0, 8'd16, 8'd16, 8'd0});
      chk("fin_done_held", 32'(done_a), 32'd1);

      rstn_a = 1'b0;
      tick();
      rstn_a = 1'b1;
      cyc = 0;
      while (wr_a != 8'd7 && cyc < 500) begin
         tick();
         cyc++;
      end
      chk("midrun_reached_wr7", 32'(wr_a), 32'd7);
      rstn_a = 1'b0;
      tick();
      chk("midrun_reset_counters", 32'({wr_a, rd_a, err_a}), 32'd0);
      chk("midrun_reset_valids", 32'(dut_valids()), 32'd0);
      chk("midrun_reset_done", 32'(done_a), 32'd0);
      repeat (2) tick();
      rstn_a = 1'b1;
      cyc = 0;
      while (!done_a && cyc < 2000) begin
         tick();
         cyc++;
      end
      chk("rerun_done", 32'(done_a), 32'd1);
      chk("rerun_counts", 32'({wr_a, rd_a, err_a}), {8'd0, 8'd16, 8'd16, 8'd0});
      chk("rerun_pass", 32'(pass_a), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
